l1_stream_fill: RTL

L2-side fill engine answering the per-stream cacheline requests raised by the L1 stream pointers. Round-robin arbitrates `nstreams` request lines and issues one L2 read per grant, carrying the stream id and that stream's next fill line id. On each in-order L2 response it writes the line into the L1 line buffer and pulses the matching per-stream cacheline response, which increments the stream's valid-line count. It also owns each stream's fill pointer, which is reloaded on a functional stream reset.

---
 rtl/l1_stream_fill.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/l1_stream_fill.sv
// L2-side fill engine: round-robin L2 read issue, in-order line return to L1.
// `L1_STREAM_FILL_ERR_EN drains unsolicited responses and flags o_err.
module l1_stream_fill #(
    parameter int nstreams   = 8,
    parameter int ncl        = 16,
    parameter int dwidth     = 512,
    parameter int maxout     = 4,
    parameter int clid_width = $clog2(ncl),
    parameter int sid_width  = $clog2(nstreams)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [nstreams-1:0]   i_clreq_v,
    output logic [nstreams-1:0]   i_clreq_r,
    input  logic                  i_rst_v,
    output logic                  i_rst_r,
    input  logic [sid_width-1:0]  i_rst_sid,
    input  logic [clid_width-1:0] i_rst_clid,
    output logic                  o_l2rd_v,
    input  logic                  o_l2rd_r,
    output logic [sid_width-1:0]  o_l2rd_sid,
    output logic [clid_width-1:0] o_l2rd_clid,
    input  logic                  i_l2rsp_v,
    output logic                  i_l2rsp_r,
    input  logic [dwidth-1:0]     i_l2rsp_d,
    output logic                  o_wr_v,
    output logic [sid_width-1:0]  o_wr_sid,
    output logic [clid_width-1:0] o_wr_clid,
    output logic [dwidth-1:0]     o_wr_d,
    output logic [nstreams-1:0]   o_clrsp_v,
    input  logic [nstreams-1:0]   i_clrsp_r,
    output logic                  o_err
);

    localparam int OCW = $clog2(maxout + 1);
    localparam int PW  = (maxout > 1) ? $clog2(maxout) : 1;
    localparam logic [OCW-1:0] FULL = OCW'(maxout);

    logic [clid_width-1:0] r_fp [nstreams];
    logic [OCW-1:0]        r_oc [nstreams];
    logic [sid_width-1:0]  r_rr;

    logic [sid_width-1:0]  r_tq_sid  [maxout];
    logic [clid_width-1:0] r_tq_clid [maxout];
    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic [OCW-1:0]        r_cnt;

    logic                  r_out_v;
    logic [sid_width-1:0]  r_out_sid;
    logic [clid_width-1:0] r_out_clid;
    logic [dwidth-1:0]     r_out_d;
    logic                  r_wr_v;

    logic                  w_full;
    logic                  w_nempty;
    logic                  w_rst_acc;
    logic [nstreams-1:0]   w_elig;
    logic [nstreams-1:0]   w_rot;
    logic                  w_any;
    logic [sid_width-1:0]  w_off;
    logic [sid_width-1:0]  w_g;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rsp_acc;
    logic                  w_clrsp_act;
    logic [sid_width-1:0]  w_hd_sid;
    logic [clid_width-1:0] w_hd_clid;
    logic [nstreams-1:0]   w_oc_inc;
    logic [nstreams-1:0]   w_oc_dec;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(maxout - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [clid_width-1:0] cl_inc(
        input logic [clid_width-1:0] c
    );
        return (c == clid_width'(ncl - 1)) ? '0 : c + 1'b1;
    endfunction

    assign w_full    = (r_cnt == FULL);
    assign w_nempty  = (r_cnt != '0);
    assign w_hd_sid  = r_tq_sid[r_rp];
    assign w_hd_clid = r_tq_clid[r_rp];

    assign i_rst_r   = (r_oc[i_rst_sid] == '0)
                     & ~(r_out_v & (r_out_sid == i_rst_sid));
    assign w_rst_acc = i_rst_v & i_rst_r;

    // A stream under functional reset this cycle must not issue.
    always_comb begin
        for (int s = 0; s < nstreams; s++) begin
            w_elig[s] = i_clreq_v[s] & ~w_full
                      & ~(w_rst_acc & (i_rst_sid == sid_width'(s)));
        end
    end

    always_comb begin
        for (int i = 0; i < nstreams; i++) begin
            w_rot[i] = w_elig[(int'(r_rr) + i) % nstreams];
        end
    end

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int i = nstreams - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_any = 1'b1;
                w_off = sid_width'(i);
            end
        end
    end

    assign w_g = sid_width'((int'(r_rr) + int'(w_off)) % nstreams);

    assign o_l2rd_v    = w_any;
    assign o_l2rd_sid  = w_g;
    assign o_l2rd_clid = r_fp[w_g];
    assign w_push      = o_l2rd_v & o_l2rd_r;

    always_comb begin
        i_clreq_r = '0;
        if (w_push) begin
            i_clreq_r[w_g] = 1'b1;
        end
    end

    assign w_clrsp_act = r_out_v & i_clrsp_r[r_out_sid];

`ifdef L1_STREAM_FILL_ERR_EN
    assign i_l2rsp_r = (w_nempty & (~r_out_v | w_clrsp_act))
                     | (~w_nempty & reset);
`else
    assign i_l2rsp_r = w_nempty & (~r_out_v | w_clrsp_act);
`endif

    assign w_rsp_acc = i_l2rsp_v & i_l2rsp_r;
    assign w_pop     = w_rsp_acc & w_nempty;

    always_comb begin
        for (int s = 0; s < nstreams; s++) begin
            w_oc_inc[s] = w_push & (w_g == sid_width'(s));
            w_oc_dec[s] = w_pop & (w_hd_sid == sid_width'(s));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr       <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_out_v    <= 1'b0;
            r_out_sid  <= '0;
            r_out_clid <= '0;
            r_wr_v     <= 1'b0;
            for (int s = 0; s < nstreams; s++) begin
                r_fp[s] <= '0;
                r_oc[s] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wp <= ptr_inc(r_wp);
                r_rr <= (w_g == sid_width'(nstreams - 1)) ? '0 : w_g + 1'b1;
            end
            if (w_pop) begin
                r_rp <= ptr_inc(r_rp);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
            r_wr_v <= w_pop;
            if (w_pop) begin
                r_out_v    <= 1'b1;
                r_out_sid  <= w_hd_sid;
                r_out_clid <= w_hd_clid;
            end else if (w_clrsp_act) begin
                r_out_v <= 1'b0;
            end
            for (int s = 0; s < nstreams; s++) begin
                if (w_rst_acc && (i_rst_sid == sid_width'(s))) begin
                    r_fp[s] <= i_rst_clid;
                end else if (w_oc_inc[s]) begin
                    r_fp[s] <= cl_inc(r_fp[s]);
                end
                case ({w_oc_inc[s], w_oc_dec[s]})
                    2'b10:   r_oc[s] <= r_oc[s] + 1'b1;
                    2'b01:   r_oc[s] <= r_oc[s] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Tag and data storage carry no reset; validity lives in r_cnt/r_out_v.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tq_sid[r_wp]  <= w_g;
            r_tq_clid[r_wp] <= o_l2rd_clid;
        end
        if (w_pop) begin
            r_out_d <= i_l2rsp_d;
        end
    end

    assign o_wr_v    = r_wr_v;
    assign o_wr_sid  = r_out_sid;
    assign o_wr_clid = r_out_clid;
    assign o_wr_d    = r_out_d;

    always_comb begin
        o_clrsp_v = '0;
        if (r_out_v) begin
            o_clrsp_v[r_out_sid] = 1'b1;
        end
    end

`ifdef L1_STREAM_FILL_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_rsp_acc && !w_nempty) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule
